// File: rtl/rowcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : rowcache_ctrl
// Description : Direct-mapped DRAM row cache controller with round-robin
//               requester arbitration and writeback/fill sequencing.
//               Optional statistics counters under ROWCACHE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module rowcache_ctrl #(
  parameter int CHWIDTH   = 5,
  parameter int ADDRWIDTH = 17,
  parameter int NREQ      = 4,
  parameter int TSYNC     = 4,
  parameter int TACC      = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  input  logic [NREQ-1:0]           req_wr,
  input  logic [NREQ*ADDRWIDTH-1:0] req_row,
  output logic [NREQ-1:0]           req_grant,
  output logic [NREQ-1:0]           req_done,
  output logic                      busy,
  output logic                      RD,
  output logic                      WR,
  output logic [ADDRWIDTH-1:0]      RowId,
  output logic [CHWIDTH-1:0]        cRowId,
  output logic                      hold,
  output logic                      sync,
  output logic [15:0]               hit_cnt,
  output logic [15:0]               miss_cnt,
  output logic [15:0]               evict_cnt
);

  localparam int C_CHROWS = 2**CHWIDTH;
  localparam int C_TAGW   = ADDRWIDTH - CHWIDTH;
  localparam int C_IW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int C_CW     = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_EVICT  = 3'd2,
    S_FILL   = 3'd3,
    S_ACCESS = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t                r_state, w_next;
  logic [C_CW-1:0]       r_cnt;
  logic                  r_wr;
  logic [ADDRWIDTH-1:0]  r_row;
  logic [C_IW-1:0]       r_idx, r_ptr;
  logic [C_CHROWS-1:0]   r_valid, r_dirty;
  logic [C_TAGW-1:0]     r_tag [C_CHROWS];

  logic [CHWIDTH-1:0]    w_slot;
  logic [C_TAGW-1:0]     w_rtag;
  logic                  w_hit, w_victim, w_last_sync, w_last_acc;
  logic [C_IW-1:0]       w_gidx, w_j;
  logic                  w_found, w_accept;

  assign w_slot      = r_row[CHWIDTH-1:0];
  assign w_rtag      = r_row[ADDRWIDTH-1:CHWIDTH];
  assign w_hit       = r_valid[w_slot] && (r_tag[w_slot] == w_rtag);
  assign w_victim    = r_valid[w_slot] && r_dirty[w_slot];
  assign w_last_sync = (r_cnt == C_CW'(TSYNC - 1));
  assign w_last_acc  = (r_cnt == C_CW'(TACC - 1));

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    w_found = 1'b0;
    w_gidx  = '0;
    w_j     = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_j = C_IW'((int'(r_ptr) + 1 + k) % NREQ);
      if (!w_found && req_valid[w_j]) begin
        w_found = 1'b1;
        w_gidx  = w_j;
      end
    end
  end

  assign w_accept = (r_state == S_IDLE) && w_found;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = S_LOOKUP;
      S_LOOKUP: begin
        if (w_hit)         w_next = S_ACCESS;
        else if (w_victim) w_next = S_EVICT;
        else               w_next = S_FILL;
      end
      S_EVICT:  if (w_last_sync) w_next = S_FILL;
      S_FILL:   if (w_last_sync) w_next = S_ACCESS;
      S_ACCESS: if (w_last_acc)  w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_wr    <= 1'b0;
      r_row   <= '0;
      r_idx   <= '0;
      r_ptr   <= C_IW'(NREQ - 1);
    end else begin
      r_state <= w_next;
      r_cnt   <= (w_next != r_state) ? '0 : r_cnt + C_CW'(1);
      if (w_accept) begin
        r_wr  <= req_wr[w_gidx];
        r_row <= req_row[int'(w_gidx)*ADDRWIDTH +: ADDRWIDTH];
        r_idx <= w_gidx;
        r_ptr <= w_gidx;
      end
    end
  end

  // Directory: the slot becomes valid and clean only when its fill completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= '0;
      r_dirty <= '0;
      for (int s = 0; s < C_CHROWS; s++) r_tag[s] <= '0;
    end else begin
      if (r_state == S_FILL && w_last_sync) begin
        r_valid[w_slot] <= 1'b1;
        r_dirty[w_slot] <= 1'b0;
        r_tag[w_slot]   <= w_rtag;
      end else if (r_state == S_ACCESS && r_wr) begin
        r_dirty[w_slot] <= 1'b1;
      end
    end
  end

  always_comb begin
    req_grant = '0;
    req_done  = '0;
    busy      = (r_state != S_IDLE);
    RD        = 1'b0;
    WR        = 1'b0;
    sync      = 1'b0;
    hold      = 1'b0;
    RowId     = '0;
    cRowId    = '0;
    if (w_accept && !rst) req_grant[w_gidx] = 1'b1;
    case (r_state)
      S_EVICT: begin
        sync   = 1'b1;
        hold   = 1'b1;
        RowId  = {r_tag[w_slot], w_slot};
        cRowId = w_slot;
      end
      S_FILL: begin
        sync   = 1'b1;
        RowId  = r_row;
        cRowId = w_slot;
      end
      S_ACCESS: begin
        RD     = ~r_wr;
        WR     = r_wr;
        RowId  = r_row;
        cRowId = w_slot;
      end
      S_DONE:  req_done[r_idx] = 1'b1;
      default: ;
    endcase
  end

`ifdef ROWCACHE_STATS_EN
  logic [15:0] r_hit_cnt, r_miss_cnt, r_evict_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hit_cnt   <= '0;
      r_miss_cnt  <= '0;
      r_evict_cnt <= '0;
    end else if (r_state == S_LOOKUP) begin
      if (w_hit) begin
        if (r_hit_cnt != 16'hFFFF) r_hit_cnt <= r_hit_cnt + 16'd1;
      end else begin
        if (r_miss_cnt != 16'hFFFF) r_miss_cnt <= r_miss_cnt + 16'd1;
        if (w_victim && r_evict_cnt != 16'hFFFF) r_evict_cnt <= r_evict_cnt + 16'd1;
      end
    end
  end

  assign hit_cnt   = r_hit_cnt;
  assign miss_cnt  = r_miss_cnt;
  assign evict_cnt = r_evict_cnt;
`else
  assign hit_cnt   = 16'd0;
  assign miss_cnt  = 16'd0;
  assign evict_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rowcache_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_rowcache_ctrl
// Description : Directed self-checking bench for rowcache_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rowcache_ctrl;

  localparam int TS = 4;
  localparam int TA = 3;
`ifdef ROWCACHE_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid, req_wr;
  logic [67:0] req_row;
  logic [3:0]  req_grant, req_done;
  logic        busy, RD, WR, hold, sync;
  logic [16:0] RowId;
  logic [4:0]  cRowId;
  logic [15:0] hit_cnt, miss_cnt, evict_cnt;
  logic [30:0] w_obs;

  int checks = 0;
  int errors = 0;

  rowcache_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wr(req_wr), .req_row(req_row),
    .req_grant(req_grant), .req_done(req_done), .busy(busy),
    .RD(RD), .WR(WR), .RowId(RowId), .cRowId(cRowId),
    .hold(hold), .sync(sync),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .evict_cnt(evict_cnt)
  );

  always #5 clk = ~clk;

  assign w_obs = {busy, RD, WR, sync, hold, RowId, cRowId, req_done};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected {busy,RD,WR,sync,hold,RowId,cRowId,req_done} c cycles after grant.
  function automatic logic [30:0] expv(input int c, input int kind, input bit w,
                                       input logic [16:0] row, input logic [16:0] vrow,
                                       input int ri);
    int e, f, l;
    logic [3:0] d;
    e = (kind == 2) ? TS : 0;
    f = (kind >= 1) ? TS : 0;
    l = e + f + TA + 2;
    d = '0;
    d[ri] = 1'b1;
    if (c == 1)             return {5'b10000, 17'd0, 5'd0, 4'd0};
    if (c < 2 + e)          return {5'b10011, vrow, row[4:0], 4'd0};
    if (c < 2 + e + f)      return {5'b10010, row, row[4:0], 4'd0};
    if (c < 2 + e + f + TA) return {1'b1, ~w, w, 2'b00, row, row[4:0], 4'd0};
    if (c == l)             return {5'b10000, 17'd0, 5'd0, d};
    return '0;
  endfunction

  // kind: 0 = hit, 1 = clean miss, 2 = dirty miss (vrow = evicted row).
  task automatic op(input int ri, input bit raise, input bit w, input logic [16:0] row,
                    input int kind, input logic [16:0] vrow, input string tag);
    int n, l;
    logic [3:0] g;
    if (raise) begin
      req_valid[ri]         = 1'b1;
      req_wr[ri]            = w;
      req_row[ri*17 +: 17]  = row;
    end
    #1;
    n = 0;
    while (req_grant == 4'd0 && n < 20) begin
      @(negedge clk); #1;
      n++;
    end
    g = '0;
    g[ri] = 1'b1;
    chk($sformatf("%s/grant", tag), req_grant, g);
    @(posedge clk); #1;
    req_valid[ri] = 1'b0;
    l = ((kind == 2) ? 2*TS : (kind == 1) ? TS : 0) + TA + 2;
    for (int c = 1; c <= l + 1; c++) begin
      @(negedge clk);
      chk($sformatf("%s/c%0d", tag, c), w_obs, expv(c, kind, w, row, vrow, ri));
      if (c <= l) chk($sformatf("%s/nogrant%0d", tag, c), req_grant, 4'd0);
    end
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    req_valid = '0;
    #1;
    chk("rstpulse/busy", busy, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = '0;
    req_wr = '0;
    req_row = '0;
    repeat (2) @(negedge clk);
    chk("reset/outs", {w_obs, req_grant}, 35'd0);
    req_valid = 4'b0001;
    #1;
    chk("reset/grant_gated", req_grant, 4'd0);
    req_valid = '0;
    chk("reset/hit", hit_cnt, 16'd0);
    chk("reset/miss", miss_cnt, 16'd0);
    chk("reset/evict", evict_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // Main flow: clean fill, hit, dirty eviction, second slot.
    op(0, 1'b1, 1'b1, 17'd150, 1, 17'd0, "wr150");
    op(0, 1'b1, 1'b0, 17'd150, 0, 17'd0, "rd150");
    chk("stats/hit1", hit_cnt, 16'(STATS));
    chk("stats/miss1", miss_cnt, 16'(STATS));
    op(1, 1'b1, 1'b1, 17'd182, 2, 17'd150, "wr182");
    chk("stats/evict1", evict_cnt, 16'(STATS));
    chk("stats/miss2", miss_cnt, 16'(2*STATS));
    op(0, 1'b1, 1'b1, 17'd590, 1, 17'd0, "wr590");
    op(0, 1'b1, 1'b0, 17'd590, 0, 17'd0, "rd590");
    op(2, 1'b1, 1'b0, 17'd182, 0, 17'd0, "rd182");
    chk("stats/hit3", hit_cnt, 16'(3*STATS));
    chk("stats/evict_still1", evict_cnt, 16'(STATS));

    // Reset during the second eviction cycle.
    rst_pulse();
    op(0, 1'b1, 1'b1, 17'd150, 1, 17'd0, "b_wr150");
    req_valid[1] = 1'b1;
    req_wr[1] = 1'b1;
    req_row[17 +: 17] = 17'd182;
    #1;
    chk("b_wr182/grant", req_grant, 4'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      chk($sformatf("b_wr182/c%0d", c), w_obs, expv(c, 2, 1'b1, 17'd182, 17'd150, 1));
    end
    rst = 1'b1;
    #1;
    chk("b_rst/outs", {w_obs, req_grant}, 35'd0);
    chk("b_rst/miss", miss_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk($sformatf("b_after/c%0d", c), w_obs, 31'd0);
    end
    op(0, 1'b1, 1'b0, 17'd150, 1, 17'd0, "b_rd150");
    chk("b_stats/miss", miss_cnt, 16'(STATS));
    chk("b_stats/hit", hit_cnt, 16'd0);

    // Round-robin: simultaneous req0 and req2 after reset.
    rst_pulse();
    req_valid[2] = 1'b1;
    req_wr[2] = 1'b0;
    req_row[34 +: 17] = 17'd182;
    op(0, 1'b1, 1'b0, 17'd150, 1, 17'd0, "c_rd150a");
    op(2, 1'b0, 1'b0, 17'd182, 1, 17'd0, "c_rd182a");
    req_valid[2] = 1'b1;
    op(0, 1'b1, 1'b0, 17'd150, 1, 17'd0, "c_rd150b");
    op(2, 1'b0, 1'b0, 17'd182, 1, 17'd0, "c_rd182b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
